// File: rtl/input_buffer_feeder_pkg.sv
// Shared types and constants for the input buffer feeder.
// INPUT_BUF_PARITY_EN widens each stored entry by one even-parity bit.
package input_buf_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

`ifdef INPUT_BUF_PARITY_EN
  localparam int ENTRY_W = DATA_W + 1;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   len_t;
  typedef logic [ENTRY_W-1:0] entry_t;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} feeder_state_e;

  // Nonzero when data plus its stored parity bit fails even parity.
  function automatic logic parity_bad(input entry_t e);
    return ^e;
  endfunction

endpackage

// File: rtl/input_buffer_feeder_if.sv
// Host-write, load-command and array-stream signals of the input buffer feeder.
// INPUT_BUF_PARITY_EN adds ext_par and parity_err.
interface input_buffer_feeder_if;
  import input_buf_pkg::*;

  word_t ext_data;
  addr_t ext_addr;
  logic  ext_wr_en;
  logic  load_start;
  addr_t load_base;
  len_t  load_len;
  word_t array_data;
  logic  array_valid;
  logic  array_ready;
  logic  busy;
  logic  done;
`ifdef INPUT_BUF_PARITY_EN
  logic  ext_par;
  logic  parity_err;
`endif

  modport slave (
    input  ext_data, ext_addr, ext_wr_en, load_start, load_base, load_len, array_ready,
`ifdef INPUT_BUF_PARITY_EN
    input  ext_par,
    output parity_err,
`endif
    output array_data, array_valid, busy, done
  );

  modport master (
    output ext_data, ext_addr, ext_wr_en, load_start, load_base, load_len, array_ready,
`ifdef INPUT_BUF_PARITY_EN
    output ext_par,
    input  parity_err,
`endif
    input  array_data, array_valid, busy, done
  );

endinterface

// File: rtl/input_buffer_feeder_mem.sv
// DEPTH-entry register file: one synchronous write port, one combinational
// read port, synchronous clear on rst.
module input_buf_mem
  import input_buf_pkg::*;
#(
  parameter int W = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr_en,
  input  addr_t        i_wr_addr,
  input  logic [W-1:0] i_wr_data,
  input  addr_t        i_rd_addr,
  output logic [W-1:0] o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read is taken before the write lands, so a same-edge write is not forwarded.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/input_buffer_feeder.sv
// Input-side staging buffer: host writes by address, load command streams a
// wrapping address range to the array. Optional INPUT_BUF_PARITY_EN parity check.
module input_buffer_feeder
  import input_buf_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  input_buffer_feeder_if.slave bus
);

  feeder_state_e r_state, w_next;
  word_t         r_data;
  addr_t         r_ptr;
  len_t          r_rem;
  addr_t         w_rd_addr;
  entry_t        w_rd_entry;
  entry_t        w_wr_entry;
  logic          w_start_go;
  logic          w_xfer;
  logic          w_last;
  logic          w_load;

  assign w_start_go = (r_state == IDLE) && bus.load_start && (bus.load_len != '0);
  assign w_xfer     = (r_state == STREAM) && bus.array_ready;
  assign w_last     = w_xfer && (r_rem == len_t'(1));
  assign w_load     = w_start_go || (w_xfer && !w_last);
  assign w_rd_addr  = (r_state == IDLE) ? bus.load_base : addr_t'(r_ptr + 1'b1);

`ifdef INPUT_BUF_PARITY_EN
  assign w_wr_entry = {bus.ext_par, bus.ext_data};
`else
  assign w_wr_entry = bus.ext_data;
`endif

  input_buf_mem #(.W(ENTRY_W)) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (bus.ext_wr_en),
    .i_wr_addr (bus.ext_addr),
    .i_wr_data (w_wr_entry),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.load_start) w_next = (bus.load_len != '0) ? STREAM : FLUSH;
      end
      STREAM: begin
        if (w_last) w_next = FLUSH;
      end
      FLUSH:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.array_valid = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    case (r_state)
      STREAM: begin
        bus.array_valid = 1'b1;
        bus.busy        = 1'b1;
      end
      FLUSH:   bus.done = 1'b1;
      default: ;
    endcase
  end

  // Stage p0: presented word, stream pointer and remaining-beat count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_ptr  <= '0;
      r_rem  <= '0;
    end else if (w_start_go) begin
      r_data <= w_rd_entry[DATA_W-1:0];
      r_ptr  <= bus.load_base;
      r_rem  <= bus.load_len;
    end else if (w_xfer && !w_last) begin
      r_data <= w_rd_entry[DATA_W-1:0];
      r_ptr  <= w_rd_addr;
      r_rem  <= r_rem - len_t'(1);
    end
  end

  assign bus.array_data = r_data;

`ifdef INPUT_BUF_PARITY_EN
  logic r_par_bad_p0;
  logic r_par_err_p1;

  // Stage p1: a bad beat loaded at one edge raises the sticky flag on the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par_bad_p0 <= 1'b0;
      r_par_err_p1 <= 1'b0;
    end else begin
      r_par_bad_p0 <= w_load && parity_bad(w_rd_entry);
      r_par_err_p1 <= r_par_err_p1 | r_par_bad_p0;
    end
  end

  assign bus.parity_err = r_par_err_p1;
`else
  logic w_unused;
  assign w_unused = w_load;
`endif

endmodule

// File: tb/tb_input_buffer_feeder.sv
// Directed self-checking bench for input_buffer_feeder.
module tb_input_buffer_feeder;
  import input_buf_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  input_buffer_feeder_if bus ();

  input_buffer_feeder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input addr_t a, input word_t d);
    bus.ext_wr_en = 1'b1;
    bus.ext_addr  = a;
    bus.ext_data  = d;
`ifdef INPUT_BUF_PARITY_EN
    bus.ext_par   = ^d;
`endif
  endtask

  task automatic start(input addr_t b, input len_t l);
    bus.load_start = 1'b1;
    bus.load_base  = b;
    bus.load_len   = l;
  endtask

  initial begin
    logic [31:0] exp_w;
    int          idx;
    logic        rdy_pat [6];
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    rst             = 1'b1;
    bus.ext_data    = '0;
    bus.ext_addr    = '0;
    bus.ext_wr_en   = 1'b0;
    bus.load_start  = 1'b0;
    bus.load_base   = '0;
    bus.load_len    = '0;
    bus.array_ready = 1'b0;
`ifdef INPUT_BUF_PARITY_EN
    bus.ext_par     = 1'b0;
`endif
    tick();
    tick();
    check("rst_data",  bus.array_data, 32'h0);
    check("rst_valid", 32'(bus.array_valid), 32'h0);
    check("rst_busy",  32'(bus.busy), 32'h0);
    check("rst_done",  32'(bus.done), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      host_write(addr_t'(i), 32'h1000 + 32'(i));
      tick();
    end
    bus.ext_wr_en = 1'b0;

    // Full-throughput stream, base 2 len 4.
    bus.array_ready = 1'b1;
    start(4'd2, 5'd4);
    tick();
    bus.load_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("s1_data",  bus.array_data, 32'h1002 + 32'(k));
      check("s1_valid", 32'(bus.array_valid), 32'h1);
      check("s1_busy",  32'(bus.busy), 32'h1);
      check("s1_done",  32'(bus.done), 32'h0);
      tick();
    end
    check("s1_done_pulse", 32'(bus.done), 32'h1);
    check("s1_valid_off",  32'(bus.array_valid), 32'h0);
    check("s1_busy_off",   32'(bus.busy), 32'h0);
    tick();
    check("s1_done_clear", 32'(bus.done), 32'h0);

    // Wrapping stream with stalls, base 14 len 4.
    start(4'd14, 5'd4);
    bus.array_ready = 1'b0;
    tick();
    bus.load_start = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      bus.array_ready = rdy_pat[c];
      exp_w = 32'h1000 + 32'((14 + idx) % 16);
      check("s2_data",  bus.array_data, exp_w);
      check("s2_valid", 32'(bus.array_valid), 32'h1);
      if (rdy_pat[c]) idx++;
      tick();
    end
    check("s2_done_pulse", 32'(bus.done), 32'h1);
    check("s2_valid_off",  32'(bus.array_valid), 32'h0);
    tick();

    // Zero-length load: no beats, done immediately.
    bus.array_ready = 1'b1;
    start(4'd3, 5'd0);
    tick();
    bus.load_start = 1'b0;
    check("z_valid", 32'(bus.array_valid), 32'h0);
    check("z_done",  32'(bus.done), 32'h1);
    check("z_busy",  32'(bus.busy), 32'h0);
    tick();
    check("z_done_clear", 32'(bus.done), 32'h0);
    check("z_valid2",     32'(bus.array_valid), 32'h0);

    // Start while busy and while flushing is ignored.
    start(4'd8, 5'd3);
    tick();
    start(4'd0, 5'd16);
    check("ig_data0", bus.array_data, 32'h1008);
    tick();
    bus.load_start = 1'b0;
    check("ig_data1", bus.array_data, 32'h1009);
    tick();
    check("ig_data2", bus.array_data, 32'h100A);
    tick();
    check("ig_done", 32'(bus.done), 32'h1);
    start(4'd1, 5'd2);
    tick();
    bus.load_start = 1'b0;
    check("ig_valid_after", 32'(bus.array_valid), 32'h0);
    check("ig_busy_after",  32'(bus.busy), 32'h0);
    check("ig_no_done",     32'(bus.done), 32'h0);

    // Same-edge write and load of address 5 sees the old word.
    start(4'd5, 5'd1);
    host_write(4'd5, 32'hDEADBEEF);
    tick();
    bus.load_start = 1'b0;
    bus.ext_wr_en  = 1'b0;
    check("rbw_old", bus.array_data, 32'h1005);
    tick();
    check("rbw_done", 32'(bus.done), 32'h1);
    tick();
    bus.array_ready = 1'b0;
    start(4'd5, 5'd1);
    tick();
    bus.load_start = 1'b0;
    check("rbw_new", bus.array_data, 32'hDEADBEEF);
    host_write(4'd5, 32'h12345678);
    tick();
    bus.ext_wr_en = 1'b0;
    check("rbw_hold", bus.array_data, 32'hDEADBEEF);
    check("rbw_hold_v", 32'(bus.array_valid), 32'h1);
    bus.array_ready = 1'b1;
    tick();
    check("rbw_done2", 32'(bus.done), 32'h1);
    tick();

    // Reset mid-stream after two transferred beats.
    start(4'd0, 5'd8);
    tick();
    bus.load_start = 1'b0;
    check("mr_b0", bus.array_data, 32'h1000);
    tick();
    tick();
    check("mr_b2", bus.array_data, 32'h1002);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_valid", 32'(bus.array_valid), 32'h0);
    check("mr_busy",  32'(bus.busy), 32'h0);
    check("mr_done",  32'(bus.done), 32'h0);
    check("mr_data",  bus.array_data, 32'h0);
    tick();
    check("mr_no_done", 32'(bus.done), 32'h0);
    check("mr_idle_v",  32'(bus.array_valid), 32'h0);

    // Full-depth stream after reset: every entry cleared.
    start(4'd7, 5'd16);
    tick();
    bus.load_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("clr_data",  bus.array_data, 32'h0);
      check("clr_valid", 32'(bus.array_valid), 32'h1);
      tick();
    end
    check("clr_done", 32'(bus.done), 32'h1);
    tick();
    check("clr_idle", 32'(bus.busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
